// File: rtl/uart_pkg.sv
// Shared constants for the UART host register block: register addresses,
// LSR/IER/FCR bit positions and IIR codes.
package uart_pkg;
    localparam logic [2:0] ADDR_RBR_THR = 3'd0;
    localparam logic [2:0] ADDR_IER     = 3'd1;
    localparam logic [2:0] ADDR_IIR_FCR = 3'd2;
    localparam logic [2:0] ADDR_LCR     = 3'd3;
    localparam logic [2:0] ADDR_MCR     = 3'd4;
    localparam logic [2:0] ADDR_LSR     = 3'd5;
    localparam logic [2:0] ADDR_MSR     = 3'd6;
    localparam logic [2:0] ADDR_SCR     = 3'd7;

    localparam int LSR_DR   = 0;
    localparam int LSR_OE   = 1;
    localparam int LSR_PE   = 3;
    localparam int LSR_FE   = 4;
    localparam int LSR_THRE = 5;
    localparam int LSR_TEMT = 6;

    localparam int IER_ERBFI  = 0;
    localparam int FCR_RX_CLR = 1;
    localparam int FCR_TX_CLR = 2;
    localparam int LCR_DLAB   = 7;

    localparam logic [7:0] IIR_NONE = 8'h01;
    localparam logic [7:0] IIR_RDA  = 8'h04;
endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO; full pushes and empty pops are
// dropped, and a clear overrides any push/pop in the same cycle.
module uart_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_clr) r_mem[r_wr_ptr] <= i_wdata;
    end
endmodule

// File: rtl/uart_host_regs.sv
// CPU-facing UART front end: register decode, LSR/IIR status, TX/RX FIFOs
// and the divisor-driven tick16/baud_tick generator.
module uart_host_regs
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs,
    input  logic       wr,
    input  logic [2:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       irq,
    output logic [7:0] lcr,
    output logic       baud_tick,
    output logic       tick16,
    input  logic       tx_pop,
    output logic [7:0] tx_data,
    output logic       tx_fifo_empty,
    input  logic       tx_idle,
    input  logic       rx_push,
    input  logic [7:0] rx_data,
    input  logic       frame_err,
    input  logic       parity_err
);
    logic [7:0]  r_dll, r_dlm, r_ier, r_lcr, r_mcr, r_scr;
    logic        r_oe;
    logic [15:0] r_div_cnt;
    logic [3:0]  r_tick_cnt;

    logic        w_dlab, w_wr, w_rd;
    logic        w_tx_push, w_rx_pop, w_rx_clr, w_tx_clr, w_div_wr;
    logic [15:0] w_divisor, w_div_new;
    logic [7:0]  w_rx_head, w_lsr, w_iir;
    logic        w_rx_empty, w_rx_full, w_dr, w_tx_full_unused;

    assign w_dlab    = r_lcr[LCR_DLAB];
    assign w_wr      = cs && wr;
    assign w_rd      = cs && !wr;
    assign w_tx_push = w_wr && (addr == ADDR_RBR_THR) && !w_dlab;
    assign w_rx_pop  = w_rd && (addr == ADDR_RBR_THR) && !w_dlab;
    assign w_rx_clr  = w_wr && (addr == ADDR_IIR_FCR) && wdata[FCR_RX_CLR];
    assign w_tx_clr  = w_wr && (addr == ADDR_IIR_FCR) && wdata[FCR_TX_CLR];
    assign w_div_wr  = w_wr && w_dlab && ((addr == ADDR_RBR_THR) || (addr == ADDR_IER));
    assign w_divisor = {r_dlm, r_dll};
    assign w_div_new = (addr == ADDR_IER) ? {wdata, r_dll} : {r_dlm, wdata};

    uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .i_clr(w_rx_clr), .i_push(rx_push), .i_pop(w_rx_pop),
        .i_wdata(rx_data), .o_rdata(w_rx_head), .o_empty(w_rx_empty), .o_full(w_rx_full)
    );

    uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .i_clr(w_tx_clr), .i_push(w_tx_push), .i_pop(tx_pop),
        .i_wdata(wdata), .o_rdata(tx_data), .o_empty(tx_fifo_empty), .o_full(w_tx_full_unused)
    );

    assign w_dr = !w_rx_empty;
    always_comb begin
        w_lsr           = 8'h00;
        w_lsr[LSR_DR]   = w_dr;
        w_lsr[LSR_OE]   = r_oe;
        w_lsr[LSR_PE]   = parity_err;
        w_lsr[LSR_FE]   = frame_err;
        w_lsr[LSR_THRE] = tx_fifo_empty;
        w_lsr[LSR_TEMT] = tx_fifo_empty && tx_idle;
    end
    assign irq   = r_ier[IER_ERBFI] && w_dr;
    assign w_iir = irq ? IIR_RDA : IIR_NONE;
    assign lcr   = r_lcr;

    always_comb begin
        rdata = 8'h00;
        case (addr)
            ADDR_RBR_THR: rdata = w_dlab ? r_dll : w_rx_head;
            ADDR_IER:     rdata = w_dlab ? r_dlm : r_ier;
            ADDR_IIR_FCR: rdata = w_iir;
            ADDR_LCR:     rdata = r_lcr;
            ADDR_MCR:     rdata = r_mcr;
            ADDR_LSR:     rdata = w_lsr;
            ADDR_MSR:     rdata = 8'h00;
            ADDR_SCR:     rdata = r_scr;
            default:      rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dll <= 8'h00;
            r_dlm <= 8'h00;
            r_ier <= 8'h00;
            r_lcr <= 8'h00;
            r_mcr <= 8'h00;
            r_scr <= 8'h00;
        end else if (w_wr) begin
            case (addr)
                ADDR_RBR_THR: if (w_dlab) r_dll <= wdata;
                ADDR_IER:     if (w_dlab) r_dlm <= wdata; else r_ier <= wdata;
                ADDR_LCR:     r_lcr <= wdata;
                ADDR_MCR:     r_mcr <= wdata;
                ADDR_SCR:     r_scr <= wdata;
                default:      ;
            endcase
        end
    end

    // A new overrun wins over a simultaneous LSR read so the event is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                r_oe <= 1'b0;
        else if (rx_push && w_rx_full)             r_oe <= 1'b1;
        else if (w_rd && (addr == ADDR_LSR))       r_oe <= 1'b0;
    end

    assign tick16    = (r_div_cnt == 16'd0) && (w_divisor != 16'd0);
    assign baud_tick = tick16 && (r_tick_cnt == 4'hF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt  <= 16'd0;
            r_tick_cnt <= 4'd0;
        end else if (w_div_wr) begin
            r_div_cnt  <= (w_div_new == 16'd0) ? 16'd0 : w_div_new - 16'd1;
            r_tick_cnt <= 4'd0;
        end else if (w_divisor != 16'd0) begin
            if (r_div_cnt == 16'd0) begin
                r_div_cnt  <= w_divisor - 16'd1;
                r_tick_cnt <= r_tick_cnt + 4'd1;
            end else begin
                r_div_cnt <= r_div_cnt - 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_uart_host_regs.sv
// Directed self-checking bench for uart_host_regs: registers, ticks, FIFOs,
// interrupt, overrun and FIFO clear.
module tb_uart_host_regs;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs = 1'b0, wr = 1'b0;
    logic [2:0] addr = 3'd0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic       irq;
    logic [7:0] lcr;
    logic       baud_tick, tick16;
    logic       tx_pop = 1'b0;
    logic [7:0] tx_data;
    logic       tx_fifo_empty;
    logic       tx_idle = 1'b1;
    logic       rx_push = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       frame_err = 1'b0, parity_err = 1'b0;

    int n_pass = 0;
    int n_total = 0;

    uart_host_regs #(.FIFO_DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata), .irq(irq), .lcr(lcr), .baud_tick(baud_tick), .tick16(tick16),
        .tx_pop(tx_pop), .tx_data(tx_data), .tx_fifo_empty(tx_fifo_empty),
        .tx_idle(tx_idle), .rx_push(rx_push), .rx_data(rx_data),
        .frame_err(frame_err), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; wr = 1'b0; addr = a;
        #1 d = rdata;
        @(negedge clk);
        cs = 1'b0;
    endtask

    task automatic peek(input logic [2:0] a, output logic [7:0] d);
        cs = 1'b0; addr = a;
        #1 d = rdata;
    endtask

    task automatic push_rx(input logic [7:0] d);
        @(negedge clk);
        rx_push = 1'b1; rx_data = d;
        @(negedge clk);
        rx_push = 1'b0;
    endtask

    task automatic pulse_tx_pop();
        @(negedge clk);
        tx_pop = 1'b1;
        @(negedge clk);
        tx_pop = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic [7:0] exp_rd [8];
        exp_rd = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h60, 8'h00, 8'h00};
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_total++;
        if ({tx_fifo_empty, irq, tick16, baud_tick, lcr} !== {4'b1000, 8'h00})
            $display("FAIL reset_outputs got empty/irq/t16/baud/lcr=%b/%b/%b/%b/%h", tx_fifo_empty, irq, tick16, baud_tick, lcr);
        else n_pass++;
        for (int a = 1; a < 8; a++) begin
            bus_read(3'(a), d);
            n_total++;
            if (d !== exp_rd[a]) $display("FAIL reset_read_addr%0d got %h exp %h", a, d, exp_rd[a]);
            else n_pass++;
        end
    endtask

    task automatic test_baud();
        logic [7:0] d;
        int t_err, b_err, t_cnt, b_cnt;
        bus_write(3'd3, 8'h80);
        bus_write(3'd0, 8'h04);
        bus_write(3'd1, 8'h00);
        t_err = 0; b_err = 0; t_cnt = 0; b_cnt = 0;
        for (int k = 0; k < 128; k++) begin
            if (tick16 !== ((k % 4) == 3)) t_err++;
            if (baud_tick !== ((k % 64) == 63)) b_err++;
            if (tick16 === 1'b1) t_cnt++;
            if (baud_tick === 1'b1) b_cnt++;
            @(negedge clk);
        end
        n_total++;
        if (t_err != 0) $display("FAIL tick16_d4_pattern got %0d bad cycles exp 0", t_err); else n_pass++;
        n_total++;
        if (b_err != 0) $display("FAIL baud_d4_pattern got %0d bad cycles exp 0", b_err); else n_pass++;
        n_total++;
        if ({t_cnt, b_cnt} !== {32'd32, 32'd2}) $display("FAIL tick_counts got %0d/%0d exp 32/2", t_cnt, b_cnt); else n_pass++;
        peek(3'd0, d);
        n_total++;
        if (d !== 8'h04) $display("FAIL dll_readback got %h exp 04", d); else n_pass++;
        bus_write(3'd0, 8'h01);
        t_err = 0;
        for (int k = 0; k < 8; k++) begin
            if (tick16 !== 1'b1) t_err++;
            @(negedge clk);
        end
        n_total++;
        if (t_err != 0) $display("FAIL tick16_d1_continuous got %0d low cycles exp 0", t_err); else n_pass++;
        bus_write(3'd0, 8'h00);
        t_err = 0;
        for (int k = 0; k < 40; k++) begin
            if (tick16 !== 1'b0 || baud_tick !== 1'b0) t_err++;
            @(negedge clk);
        end
        n_total++;
        if (t_err != 0) $display("FAIL ticks_halted_d0 got %0d active cycles exp 0", t_err); else n_pass++;
        bus_write(3'd3, 8'h03);
    endtask

    task automatic test_tx();
        logic [7:0] d;
        bus_write(3'd0, 8'hA5);
        bus_write(3'd0, 8'h3C);
        n_total++;
        if ({tx_data, tx_fifo_empty} !== {8'hA5, 1'b0})
            $display("FAIL tx_head_first got %h/%b exp a5/0", tx_data, tx_fifo_empty);
        else n_pass++;
        bus_read(3'd5, d);
        n_total++;
        if (d !== 8'h00) $display("FAIL tx_lsr_thre got %h exp 00", d); else n_pass++;
        pulse_tx_pop();
        n_total++;
        if (tx_data !== 8'h3C) $display("FAIL tx_head_second got %h exp 3c", tx_data); else n_pass++;
        pulse_tx_pop();
        n_total++;
        if (tx_fifo_empty !== 1'b1) $display("FAIL tx_empty_after_pops got %b exp 1", tx_fifo_empty); else n_pass++;
    endtask

    task automatic test_rx_irq();
        logic [7:0] d;
        bus_write(3'd1, 8'h01);
        push_rx(8'h55);
        n_total++;
        if (irq !== 1'b1) $display("FAIL rx_irq_set got %b exp 1", irq); else n_pass++;
        bus_read(3'd2, d);
        n_total++;
        if (d !== 8'h04) $display("FAIL rx_iir_rda got %h exp 04", d); else n_pass++;
        peek(3'd0, d);
        n_total++;
        if (d !== 8'h55) $display("FAIL rx_head_peek got %h exp 55", d); else n_pass++;
        bus_read(3'd0, d);
        n_total++;
        if (d !== 8'h55) $display("FAIL rx_read got %h exp 55", d); else n_pass++;
        peek(3'd5, d);
        n_total++;
        if ({d, irq} !== {8'h60, 1'b0}) $display("FAIL rx_after_read lsr/irq got %h/%b exp 60/0", d, irq); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            rx_push = 1'b1; rx_data = 8'(i);
            @(negedge clk);
        end
        rx_push = 1'b0;
        peek(3'd5, d);
        n_total++;
        if (d !== 8'h63) $display("FAIL ovf_lsr_oe got %h exp 63", d); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            bus_read(3'd0, d);
            n_total++;
            if (d !== 8'(i)) $display("FAIL ovf_read%0d got %h exp %h", i, d, 8'(i)); else n_pass++;
        end
        bus_read(3'd5, d);
        n_total++;
        if (d !== 8'h62) $display("FAIL ovf_lsr_drained got %h exp 62", d); else n_pass++;
        peek(3'd5, d);
        n_total++;
        if (d !== 8'h60) $display("FAIL ovf_oe_cleared got %h exp 60", d); else n_pass++;
    endtask

    task automatic test_regs();
        logic [7:0] d;
        bus_write(3'd4, 8'h1F);
        bus_write(3'd7, 8'hA5);
        bus_write(3'd6, 8'hFF);
        bus_write(3'd1, 8'h0E);
        bus_read(3'd4, d);
        n_total++;
        if (d !== 8'h1F) $display("FAIL mcr_rw got %h exp 1f", d); else n_pass++;
        bus_read(3'd7, d);
        n_total++;
        if (d !== 8'hA5) $display("FAIL scr_rw got %h exp a5", d); else n_pass++;
        bus_read(3'd6, d);
        n_total++;
        if (d !== 8'h00) $display("FAIL addr6_ignored got %h exp 00", d); else n_pass++;
        bus_read(3'd1, d);
        n_total++;
        if (d !== 8'h0E) $display("FAIL ier_rw got %h exp 0e", d); else n_pass++;
        bus_write(3'd3, 8'h83);
        bus_read(3'd1, d);
        n_total++;
        if (d !== 8'h00) $display("FAIL dlm_vs_ier got %h exp 00", d); else n_pass++;
        bus_write(3'd3, 8'h03);
    endtask

    task automatic test_fcr_clear();
        logic [7:0] d;
        push_rx(8'h11);
        push_rx(8'h22);
        push_rx(8'h33);
        bus_write(3'd0, 8'h77);
        bus_write(3'd2, 8'h02);
        peek(3'd5, d);
        n_total++;
        if (d !== 8'h00) $display("FAIL fcr_rx_clear_lsr got %h exp 00", d); else n_pass++;
        n_total++;
        if ({tx_data, tx_fifo_empty} !== {8'h77, 1'b0})
            $display("FAIL fcr_tx_untouched got %h/%b exp 77/0", tx_data, tx_fifo_empty);
        else n_pass++;
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = 3'd2; wdata = 8'h06;
        rx_push = 1'b1; rx_data = 8'h99;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; rx_push = 1'b0;
        parity_err = 1'b1; frame_err = 1'b1;
        peek(3'd5, d);
        n_total++;
        if (d !== 8'h78) $display("FAIL fcr_clear_beats_push lsr got %h exp 78", d); else n_pass++;
        tx_idle = 1'b0;
        peek(3'd5, d);
        n_total++;
        if (d !== 8'h38) $display("FAIL lsr_temt_busy got %h exp 38", d); else n_pass++;
        tx_idle = 1'b1; parity_err = 1'b0; frame_err = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [7:0] d;
        bus_write(3'd0, 8'hEE);
        push_rx(8'h44);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({lcr, tx_fifo_empty, irq} !== {8'h00, 1'b1, 1'b0})
            $display("FAIL async_reset got lcr/empty/irq=%h/%b/%b exp 00/1/0", lcr, tx_fifo_empty, irq);
        else n_pass++;
        peek(3'd7, d);
        n_total++;
        if (d !== 8'h00) $display("FAIL async_reset_scr got %h exp 00", d); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_baud();
        test_tx();
        test_rx_irq();
        test_overflow();
        test_regs();
        test_fcr_clear();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
